// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : RV32I OP/OP-IMM decode + register read, one-entry output reg
// Revision     : 1.0
// ============================================================================
`default_nettype none

module decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_fn,
  output logic [6:0]       out_funct7,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [4:0]       out_rd,
  output logic             illegal
);

  localparam logic [6:0] c_OPC_OP  = 7'b0110011;
  localparam logic [6:0] c_OPC_IMM = 7'b0010011;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;
  localparam logic       c_EMPTY   = 1'b0;
  localparam logic       c_FULL    = 1'b1;

  logic [WIDTH-1:0] r_regs [32];
  logic             r_state;
  logic             w_state_nxt;
  logic             r_illegal;
  logic [2:0]       r_fn;
  logic [6:0]       r_funct7;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [4:0]       r_rd;

  logic [6:0]       w_opcode;
  logic [4:0]       w_rd;
  logic [2:0]       w_f3;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [6:0]       w_f7;
  logic [11:0]      w_imm;
  logic [WIDTH-1:0] w_rs1_val;
  logic [WIDTH-1:0] w_rs2_val;
  logic [WIDTH-1:0] w_b;
  logic [6:0]       w_funct7;
  logic             w_legal;
  logic             w_accept;
  logic             w_load;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_f3     = in_instr[14:12];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_f7     = in_instr[31:25];
  assign w_imm    = in_instr[31:20];

  // Same-cycle writeback is forwarded so the read sees the value landing now
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 :
                     (wb_en && wb_rd == w_rs1) ? wb_data : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 :
                     (wb_en && wb_rd == w_rs2) ? wb_data : r_regs[w_rs2];

  always_comb begin
    w_legal  = 1'b0;
    w_funct7 = 7'd0;
    w_b      = w_rs2_val;
    case (w_opcode)
      c_OPC_OP: begin
        if (w_f7 == 7'd0) begin
          w_legal = 1'b1;
        end else if (w_f7 == c_F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          w_legal  = 1'b1;
          w_funct7 = c_F7_ALT;
        end
      end
      c_OPC_IMM: begin
        w_b = {{(WIDTH-12){w_imm[11]}}, w_imm};
        case (w_f3)
          3'b001: begin
            w_b     = {{(WIDTH-5){1'b0}}, w_imm[4:0]};
            w_legal = (w_imm[11:5] == 7'd0);
          end
          3'b101: begin
            w_b      = {{(WIDTH-5){1'b0}}, w_imm[4:0]};
            w_legal  = (w_imm[11:5] == 7'd0) || (w_imm[11:5] == c_F7_ALT);
            w_funct7 = w_imm[11:5];
          end
          default: w_legal = 1'b1;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_accept = in_valid && in_ready;
  assign w_load   = w_accept && w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_EMPTY: if (w_load) w_state_nxt = c_FULL;
      c_FULL:  if (out_ready && !w_load) w_state_nxt = c_EMPTY;
      default: w_state_nxt = c_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (r_state == c_FULL);
    in_ready  = !out_valid || out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fn      <= 3'd0;
      r_funct7  <= 7'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_rd      <= 5'd0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_load) begin
        r_fn     <= w_f3;
        r_funct7 <= w_funct7;
        r_a      <= w_rs1_val;
        r_b      <= w_b;
        r_rd     <= w_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  assign out_fn     = r_fn;
  assign out_funct7 = r_funct7;
  assign out_a      = r_a;
  assign out_b      = r_b;
  assign out_rd     = r_rd;
  assign illegal    = r_illegal;

endmodule

`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Decode and register-read stage feeding the ALU. Accepts RV32I OP and OP-IMM instruction words over a valid/ready handshake and reads operands from an internal 32-entry register file with a writeback port. Produces the `alu_fn_t` function, `funct7_t` qualifier and both operands in a one-entry output register consumed by the execute stage. Every other opcode is rejected with a one-cycle illegal flag.

## Interface
- `WIDTH`, default 32: register and operand width. Immediates are sign-extended to `WIDTH`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: instruction word.
- `wb_en` in 1: register-file write enable.
- `wb_rd` in 5: write address.
- `wb_data` in WIDTH: write data.
- `out_valid` out 1: output register holds a decoded op.
- `out_ready` in 1: execute stage consumes this cycle.
- `out_fn` out alu_fn_t: ALU function, equal to funct3 encoding.
- `out_funct7` out funct7_t: 7'b0000000, or 7'b0100000 for SUB/SRA.
- `out_a` out WIDTH: operand a, the rs1 value.
- `out_b` out WIDTH: operand b, the rs2 value, the immediate, or shamt.
- `out_rd` out 5: destination register.
- `illegal` out 1: one-cycle pulse for a rejected instruction.

## Operation
- Accept condition: `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational.
- Output register has two states:
  - EMPTY→FULL on accept of a legal op.
  - FULL→EMPTY on `out_ready` with no legal accept.
  - FULL→FULL on `out_ready` with a legal accept; new data loads.
  - FULL holds all outputs stable while `out_ready` is 0.
- OP (0110011):
  - funct7 0000000: any funct3 is legal.
  - funct7 0100000: legal only for funct3 000 or 101.
  - Any other funct7 is illegal, including MUL (0000001).
  - `out_b` = rs2 value.
- OP-IMM (0010011):
  - `out_b` = sign-extended imm[11:0].
  - Non-shift ops: `out_funct7` forced to 0. ADDI must never subtract.
  - SLLI: imm[11:5] must be 0. `out_b` = zero-extended shamt imm[4:0].
  - SRLI/SRAI: imm[11:5] must be 0 or 0100000, which is passed as `out_funct7`. `out_b` = shamt.
- Any other opcode is illegal.
- Illegal accept: `in_ready` rules are unchanged and the instruction is consumed. `illegal`=1 the next cycle. The output register is not loaded but may still drain.
- Register file:
  - x0 reads 0. Writes to x0 are ignored.
  - A write lands at the rising edge when `wb_en`=1.
  - Bypass: a read of rs where `wb_en && wb_rd==rs && rs!=0` in the accept cycle returns `wb_data`.

## Timing
- Reset values: `out_valid`, `illegal`, `out_fn`, `out_funct7`, `out_a`, `out_b` and `out_rd` are all 0. All 32 registers are 0. `in_ready`=1.
- Reset mid-operation clears a held op immediately with no drain.
- Latency: accept at edge N gives `out_valid`=1 after edge N, with fields registered at N.
- Throughput: one op per cycle while `out_ready`=1.
- `illegal` is registered and asserted for exactly one cycle per illegal accept.
- Decode and register read are combinational from `in_instr` in the accept cycle. No state depends on `in_instr` when not accepting.
- Writeback in the accept cycle is visible through bypass. Writeback after the accept does not alter a held `out_a`/`out_b`.

## Test plan
- Reset, then write x1=5 and x2=3, then ADD 0x002081B3 → next cycle `out_valid`=1, `out_fn`=ADD_SUB, `out_funct7`=0, `out_a`=5, `out_b`=3, `out_rd`=3.
- SUB 0x402081B3 → `out_funct7`=0x20. MUL 0x022081B3 → `illegal` pulses for one cycle and `out_valid` stays 0.
- ADDI 0xFFF00093 → `out_a`=0, `out_b`=0xFFFFFFFF, `out_funct7`=0. SRAI 0x4030D293 → `out_fn`=SRL_SRA, `out_funct7`=0x20, `out_b`=3.
- Backpressure: hold `out_ready`=0 with two queued ADDs.
  - `in_ready` goes 0 while the first op is held.
  - Outputs stay stable for 5 cycles.
  - Raising `out_ready` drains the first op and loads the second in the same edge.
- Bypass: `wb_en`=1, `wb_rd`=1, `wb_data`=0x1234 in the accept cycle of ADD x3,x1,x2 → `out_a`=0x1234. A write to x0 of 0xFF followed by a read of x0 → 0.
- Assert `rst_n`=0 asynchronously while `out_valid`=1 → `out_valid` drops before the next edge. After release, x1 reads 0.
